// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: FSM encoding and default widths that the
// neighbouring EX/MEM and MEM/WB stages also size themselves from.
package mem_access_stage_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_REG_W    = 4;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_WAIT_MAX = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);

  // dmem_req rises with addr/we/wdata stable and stays high until the cycle dmem_ack
  // is seen (or the stage gives up); dmem_ack is a single-cycle strobe and dmem_rdata
  // is only meaningful in that cycle.
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_access_stage_wait_timer.sv
// Wait-state counter for an outstanding memory access; tc flags that WAIT_MAX
// ack-less cycles have already been counted.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int TW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [TW-1:0] TC_VAL = TW'(WAIT_MAX);

  logic [TW-1:0] count_q, count_d;

  assign tc = (count_q == TC_VAL);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !tc) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU results through, runs loads/stores over the
// req/ack data port with a bounded wait, and feeds the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_W    = DEF_REG_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WAIT_MAX = DEF_WAIT_MAX
) (
  input  logic              nclk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  ex_reg_dest,
  input  logic              ex_reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              stall,
  mem_access_stage_if.master dmem,
  output logic [DATA_W-1:0] data_to_reg,
  output logic [REG_W-1:0]  reg_dest,
  output logic              reg_write,
  output logic              bus_err,
  output mem_state_e        dbg_state
);

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_W-1:0]  lat_dest_q, lat_dest_d;
  logic              lat_rw_q, lat_rw_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              rw_q, rw_d;
  logic              err_q, err_d;
  logic              timer_clear, timer_en, timer_tc;

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk    (nclk),
    .rst_n  (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .tc     (timer_tc)
  );

  // An ack arriving in the terminal wait cycle still completes, so it masks the abort.
  assign stall = (state_q == ST_BUSY) & ~dmem.dmem_ack & ~timer_tc;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_dest_d  = lat_dest_q;
    lat_rw_d    = lat_rw_q;
    data_d      = data_q;
    dest_d      = dest_q;
    rw_d        = 1'b0;
    err_d       = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (mem_read && mem_write) begin
            err_d = 1'b1;
          end else if (mem_read || mem_write) begin
            req_d       = 1'b1;
            we_d        = mem_write;
            addr_d      = alu_result[ADDR_W-1:0];
            wdata_d     = store_data;
            lat_dest_d  = ex_reg_dest;
            lat_rw_d    = ex_reg_write;
            timer_clear = 1'b1;
            state_d     = ST_BUSY;
          end else begin
            data_d = alu_result;
            dest_d = ex_reg_dest;
            rw_d   = ex_reg_write;
          end
        end
      end
      ST_BUSY: begin
        if (dmem.dmem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
          if (!we_q) begin
            data_d = dmem.dmem_rdata;
            dest_d = lat_dest_q;
            rw_d   = lat_rw_q;
          end
        end else if (timer_tc) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_dest_q <= '0;
      lat_rw_q   <= 1'b0;
      data_q     <= '0;
      dest_q     <= '0;
      rw_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_dest_q <= lat_dest_d;
      lat_rw_q   <= lat_rw_d;
      data_q     <= data_d;
      dest_q     <= dest_d;
      rw_q       <= rw_d;
      err_q      <= err_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign data_to_reg     = data_q;
  assign reg_dest        = dest_q;
  assign reg_write       = rw_q;
  assign bus_err         = err_q;
  assign dbg_state       = state_q;

endmodule
